audio_uart_streamer: RTL



---
 rtl/audio_uart_streamer.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/audio_uart_streamer.sv
// Multi-channel audio frame capture, frame FIFO and 8N1 UART serialiser.
// Optional frame header (0xA5 + sequence number) enabled by STREAMER_SYNC_EN.
module audio_uart_streamer #(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_W   = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD_RATE  = 921_600
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [NUM_CH-1:0][SAMPLE_W-1:0]    audio_in,
  input  logic                               valid_in,
  input  logic                               enable_in,
  input  logic [NUM_CH-1:0]                  ch_mask_in,
  input  logic [3:0]                         decim_in,
  output logic                               tx_wire_out,
  output logic                               busy_out,
  output logic                               overflow_out,
  output logic [15:0]                        dropped_out
);

  localparam int BIT_P = CLK_HZ / BAUD_RATE;
  localparam int BCW   = $clog2(BIT_P + 1);
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CIW   = CHW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  // Lowest masked channel at or above 'from'; NUM_CH when none is left.
  function automatic logic [CIW-1:0] first_ch(input logic [NUM_CH-1:0] m,
                                              input logic [CIW-1:0] from);
    logic [CIW-1:0] r;
    r = CIW'(NUM_CH);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (CIW'(i) >= from)) r = CIW'(i);
    end
    return r;
  endfunction

  function automatic logic [7:0] samp_byte(input logic [NUM_CH-1:0][15:0] s,
                                           input logic [CIW-1:0] ch,
                                           input logic hi);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CIW'(i)) r = hi ? s[i][15:8] : s[i][7:0];
    end
    return r;
  endfunction

  logic [NUM_CH-1:0][15:0] mem_samp [FIFO_DEPTH];
  logic [NUM_CH-1:0]       mem_mask [FIFO_DEPTH];
  logic [AW-1:0]           wp_q, rp_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [3:0]              dec_q, dec_d;
  logic                    ovf_q;
  logic [15:0]             drop_q;
  logic [NUM_CH-1:0][15:0] cap_samp;
  logic                    cand, store, full, push, drop, pop, load, bit_end, more;

  state_t                  state_q, state_d;
  logic [BCW-1:0]          baud_q, baud_d;
  logic [2:0]              bit_q, bit_d;
  logic [7:0]              sh_q, sh_d;
  logic [CIW-1:0]          ch_q, ch_d, nxt_ch;
  logic                    hi_q, hi_d;
  logic [NUM_CH-1:0][15:0] fr_samp_q, fr_samp_d;
  logic [NUM_CH-1:0]       fr_mask_q, fr_mask_d;
  logic                    tx_q, tx_d, busy_q, busy_d;
`ifdef STREAMER_SYNC_EN
  logic [1:0]              hdr_q, hdr_d;
  logic [7:0]              seq_q, seq_d, fr_seq_q, fr_seq_d;
`endif

  // Decimation: the first valid frame after reset/enable is captured, then
  // every (decim_in+1)-th one.
  always_comb begin
    dec_d = dec_q;
    cand  = 1'b0;
    if (!enable_in) begin
      dec_d = 4'd0;
    end else if (valid_in) begin
      cand  = (dec_q == 4'd0);
      dec_d = (dec_q >= decim_in) ? 4'd0 : dec_q + 4'd1;
    end else begin
      dec_d = dec_q;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      cap_samp[i] = audio_in[i][SAMPLE_W-1 -: 16];
    end
    store = cand && (ch_mask_in != {NUM_CH{1'b0}});
    full  = (cnt_q == CW'(FIFO_DEPTH));
    push  = store && !full;
    drop  = store && full;
  end

  // Serialiser next-state; the byte-advance decision is folded into the last
  // STOP cycle so consecutive bytes and frames leave without idle gaps.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    ch_d      = ch_q;
    hi_d      = hi_q;
    fr_samp_d = fr_samp_q;
    fr_mask_d = fr_mask_q;
    pop       = 1'b0;
    load      = 1'b0;
    more      = 1'b0;
    bit_end   = (baud_q == BCW'(BIT_P - 1));
    nxt_ch    = first_ch(fr_mask_q, ch_q + CIW'(1));
`ifdef STREAMER_SYNC_EN
    hdr_d     = hdr_q;
    seq_d     = seq_q;
    fr_seq_d  = fr_seq_q;
`endif
    if (state_q == START || state_q == DATA || state_q == STOP) begin
      baud_d = bit_end ? {BCW{1'b0}} : baud_q + BCW'(1);
    end else begin
      baud_d = {BCW{1'b0}};
    end

    case (state_q)
      IDLE: begin
        if (cnt_q != {CW{1'b0}}) state_d = LOAD;
        else                     state_d = IDLE;
      end
      LOAD: begin
        load    = 1'b1;
        state_d = START;
      end
      START: begin
        if (bit_end) state_d = DATA;
        else         state_d = START;
      end
      DATA: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (bit_end) begin
`ifdef STREAMER_SYNC_EN
          if (hdr_q != 2'd2) begin
            hdr_d = hdr_q + 2'd1;
            more  = 1'b1;
          end else
`endif
          if (hi_q) begin
            hi_d = 1'b0;
            more = 1'b1;
          end else if (nxt_ch != CIW'(NUM_CH)) begin
            ch_d = nxt_ch;
            hi_d = 1'b1;
            more = 1'b1;
          end else begin
            more = 1'b0;
          end
          if (more) begin
            state_d = START;
          end else if (cnt_q != {CW{1'b0}}) begin
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      pop       = 1'b1;
      fr_samp_d = mem_samp[rp_q];
      fr_mask_d = mem_mask[rp_q];
      ch_d      = first_ch(mem_mask[rp_q], {CIW{1'b0}});
      hi_d      = 1'b1;
`ifdef STREAMER_SYNC_EN
      hdr_d     = 2'd0;
      fr_seq_d  = seq_q;
      seq_d     = seq_q + 8'd1;
`endif
    end else begin
      pop = 1'b0;
    end

    if (state_d == START && state_q != START) begin
`ifdef STREAMER_SYNC_EN
      case (hdr_d)
        2'd0:    sh_d = 8'hA5;
        2'd1:    sh_d = fr_seq_d;
        default: sh_d = samp_byte(fr_samp_d, ch_d, hi_d);
      endcase
`else
      sh_d = samp_byte(fr_samp_d, ch_d, hi_d);
`endif
    end else begin
      sh_d = sh_d;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase

    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    busy_d = (state_d != IDLE) || (cnt_d != {CW{1'b0}});
  end

  // Frame storage; contents are qualified by the reset pointers and count.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_samp[wp_q] <= cap_samp;
      mem_mask[wp_q] <= ch_mask_in;
    end
  end

  // Control, accounting and serialiser registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wp_q      <= {AW{1'b0}};
      rp_q      <= {AW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      dec_q     <= 4'd0;
      ovf_q     <= 1'b0;
      drop_q    <= 16'd0;
      state_q   <= IDLE;
      baud_q    <= {BCW{1'b0}};
      bit_q     <= 3'd0;
      sh_q      <= 8'h00;
      ch_q      <= {CIW{1'b0}};
      hi_q      <= 1'b0;
      fr_samp_q <= '0;
      fr_mask_q <= {NUM_CH{1'b0}};
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef STREAMER_SYNC_EN
      hdr_q     <= 2'd0;
      seq_q     <= 8'd0;
      fr_seq_q  <= 8'd0;
`endif
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      cnt_q     <= cnt_d;
      dec_q     <= dec_d;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      ch_q      <= ch_d;
      hi_q      <= hi_d;
      fr_samp_q <= fr_samp_d;
      fr_mask_q <= fr_mask_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef STREAMER_SYNC_EN
      hdr_q     <= hdr_d;
      seq_q     <= seq_d;
      fr_seq_q  <= fr_seq_d;
`endif
    end
  end

  assign tx_wire_out  = tx_q;
  assign busy_out     = busy_q;
  assign overflow_out = ovf_q;
  assign dropped_out  = drop_q;

endmodule
